gen_bypassqueue: RTL and testbench

GEN_BYPASSQUEUE -- requirements
Module: gen_bypassqueue

---
 rtl/gen_bypassqueue.sv | 88 ++++++++
 tb/tb_gen_bypassqueue.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/gen_bypassqueue.sv
// Bypass queue: DP-entry circular buffer. When the queue is empty and downstream is ready,
// input passes straight through with zero latency.
module gen_bypassqueue #(
    parameter int unsigned DW = 64,
    parameter int unsigned DP = 4,
    parameter int unsigned AW = $clog2(DP)
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          valid_i,
    input  logic [DW-1:0] data_i,
    output logic          ready_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o,
    input  logic          ready_o,
    input  logic          flush,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full
);

    localparam logic [AW:0] DpCnt = (AW+1)'(DP);

    logic [DW-1:0] mem_q [DP];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          push, pop, bypass;

    assign count   = count_q;
    assign empty   = (count_q == '0);
    assign full    = (count_q == DpCnt);
    assign ready_i = ~full | flush;
    assign valid_o = (~empty | valid_i) & ~flush;
    assign data_o  = empty ? data_i : mem_q[rd_ptr_q];

    assign bypass = empty & valid_i & ready_o & ~flush;
    assign push   = valid_i & ready_i & ~flush & ~bypass;
    assign pop    = valid_o & ready_o & ~empty & ~flush;

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DP; i++) begin
                mem_q[AW'(i)] <= '0;
            end
        end else begin
            count_q <= count_d;
            // Flush rewinds the pointers but leaves storage contents intact.
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) begin
                    mem_q[wr_ptr_q] <= data_i;
                    wr_ptr_q        <= wr_ptr_q + 1'b1;
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                end
            end
        end
    end

`ifndef SYNTHESIS
    always @(posedge CLK) begin
        if (RSTn && ((count_q > DpCnt) || (push && full))) begin
            $display("Assert Fail at bypass queue");
            $finish;
        end
    end
`endif

endmodule

// File: tb/tb_gen_bypassqueue.sv
// Directed bench for gen_bypassqueue (DW=8, DP=4): vector table plus hand-written
// sequences for wrap, flush and asynchronous reset.
module tb_gen_bypassqueue;

    localparam int unsigned DW = 8;
    localparam int unsigned DP = 4;
    localparam int unsigned AW = 2;

    logic          CLK;
    logic          RSTn;
    logic          valid_i;
    logic [DW-1:0] data_i;
    logic          ready_i;
    logic          valid_o;
    logic [DW-1:0] data_o;
    logic          ready_o;
    logic          flush;
    logic [AW:0]   count;
    logic          empty;
    logic          full;

    int checks = 0;
    int errors = 0;
    bit seen_aa = 1'b0;

    gen_bypassqueue #(.DW(DW), .DP(DP)) dut (
        .CLK     (CLK),
        .RSTn    (RSTn),
        .valid_i (valid_i),
        .data_i  (data_i),
        .ready_i (ready_i),
        .valid_o (valid_o),
        .data_o  (data_o),
        .ready_o (ready_o),
        .flush   (flush),
        .count   (count),
        .empty   (empty),
        .full    (full)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // 0xAA is only ever offered during a flush cycle, so it must never be seen valid.
    always @(negedge CLK) begin
        if (RSTn && valid_o && data_o == 8'hAA) seen_aa = 1'b1;
    end

    typedef struct {
        logic          v;
        logic [DW-1:0] d;
        logic          r;
        logic          f;
        logic          e_valid;
        logic [DW-1:0] e_data;
        logic          e_ready;
        logic [AW:0]   e_count;
        logic          e_empty;
        logic          e_full;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
        valid_i = v;
        data_i  = d;
        ready_o = r;
        flush   = f;
    endtask

    task automatic check_all(input string tag, input logic ev, input logic [DW-1:0] ed,
                             input logic er, input logic [AW:0] ec, input logic ee,
                             input logic ef);
        chk({tag, ".valid_o"}, 32'(valid_o), 32'(ev));
        chk({tag, ".data_o"},  32'(data_o),  32'(ed));
        chk({tag, ".ready_i"}, 32'(ready_i), 32'(er));
        chk({tag, ".count"},   32'(count),   32'(ec));
        chk({tag, ".empty"},   32'(empty),   32'(ee));
        chk({tag, ".full"},    32'(full),    32'(ef));
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        //        v  d      r  f  valid data   rdy cnt emp full
        vecs[0]  = '{0, 8'h00, 0, 0, 0, 8'h00, 1, 0, 1, 0}; // idle after reset
        vecs[1]  = '{1, 8'h11, 1, 0, 1, 8'h11, 1, 0, 1, 0}; // bypass
        vecs[2]  = '{0, 8'h00, 1, 0, 0, 8'h00, 1, 0, 1, 0}; // bypass left count at 0
        vecs[3]  = '{1, 8'h01, 0, 0, 1, 8'h01, 1, 0, 1, 0}; // empty, stalled: store
        vecs[4]  = '{1, 8'h02, 0, 0, 1, 8'h01, 1, 1, 0, 0};
        vecs[5]  = '{1, 8'h03, 0, 0, 1, 8'h01, 1, 2, 0, 0};
        vecs[6]  = '{1, 8'h04, 0, 0, 1, 8'h01, 1, 3, 0, 0};
        vecs[7]  = '{1, 8'h05, 0, 0, 1, 8'h01, 0, 4, 0, 1}; // full, 5th held off
        vecs[8]  = '{0, 8'h00, 1, 0, 1, 8'h01, 0, 4, 0, 1}; // drain begins
        vecs[9]  = '{0, 8'h00, 1, 0, 1, 8'h02, 1, 3, 0, 0}; // ready_i back after pop
        vecs[10] = '{0, 8'h00, 1, 0, 1, 8'h03, 1, 2, 0, 0};
        vecs[11] = '{0, 8'h00, 1, 0, 1, 8'h04, 1, 1, 0, 0};
        vecs[12] = '{0, 8'h00, 0, 0, 0, 8'h00, 1, 0, 1, 0}; // drained

        RSTn = 1'b0;
        drive(0, 8'h00, 0, 0);
        #12;
        RSTn = 1'b1;

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].v, vecs[i].d, vecs[i].r, vecs[i].f);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_data,
                      vecs[i].e_ready, vecs[i].e_count, vecs[i].e_empty, vecs[i].e_full);
            tick();
        end

        // Wrap with concurrent push/pop at count=2: output lags input by two entries.
        drive(1, 8'h20, 0, 0); tick();
        drive(1, 8'h21, 0, 0); tick();
        for (int i = 0; i < 10; i++) begin
            drive(1, 8'(8'h22 + i), 1, 0);
            #1;
            chk($sformatf("wrap%0d.data_o", i), 32'(data_o), 32'(8'h20 + i));
            chk($sformatf("wrap%0d.count", i), 32'(count), 32'd2);
            tick();
        end
        chk("wrap.count_end", 32'(count), 32'd2);

        // Reach count=3, then flush while offering 0xAA.
        drive(1, 8'h30, 0, 0); tick();
        chk("preflush.count", 32'(count), 32'd3);
        drive(1, 8'hAA, 1, 1);
        #1;
        chk("flush.valid_o", 32'(valid_o), 32'd0);
        chk("flush.ready_i", 32'(ready_i), 32'd1);
        tick();
        drive(0, 8'h00, 1, 0);
        #1;
        check_all("postflush", 0, 8'h00, 1, 0, 1, 0);
        tick();
        drive(1, 8'h5A, 1, 0);
        #1;
        chk("postflush.bypass", 32'(data_o), 32'h5A);
        tick();

        // Asynchronous reset between edges with two entries stored.
        drive(1, 8'h41, 0, 0); tick();
        drive(1, 8'h42, 0, 0); tick();
        drive(1, 8'h55, 0, 0);
        #1;
        chk("prereset.count", 32'(count), 32'd2);
        chk("prereset.data_o", 32'(data_o), 32'h41);
        #1;
        RSTn = 1'b0;
        #1;
        check_all("inreset", 1, 8'h55, 1, 0, 1, 0);
        #1;
        RSTn = 1'b1;
        drive(1, 8'h11, 1, 0);
        #1;
        check_all("postreset.bypass", 1, 8'h11, 1, 0, 1, 0);
        tick();
        drive(0, 8'h00, 1, 0);
        #1;
        chk("postreset.count", 32'(count), 32'd0);
        tick();

        chk("no_flushed_data", 32'(seen_aa), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
